// File: rtl/multi_dim_array_regs.sv
// Self-running pattern source: a 2x2 array of free-running counters plus per-row 3-stage sum delay lines.
// Optional macro MULTI_DIM_ARRAY_HOLD_EN adds a HOLD input that freezes all state (RST still wins).
module multi_dim_array_regs #(
    parameter int BIT_WIDTH_REG_1 = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
`ifdef MULTI_DIM_ARRAY_HOLD_EN
    input  logic                       HOLD,
`endif
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_1_A,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_1_B,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_1_C,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_1_D,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_2_A,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_2_B,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_2_C,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_2_D,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_2_E,
    output logic [BIT_WIDTH_REG_1-1:0] OUT_REG_2_F
);

    localparam logic [BIT_WIDTH_REG_1-1:0] ONE = BIT_WIDTH_REG_1'(1);

    logic [BIT_WIDTH_REG_1-1:0] reg_1_q [2][2];
    logic [BIT_WIDTH_REG_1-1:0] reg_1_d [2][2];
    logic [BIT_WIDTH_REG_1-1:0] reg_2_q [2][3];
    logic [BIT_WIDTH_REG_1-1:0] reg_2_d [2][3];
    logic                       hold_w;

`ifdef MULTI_DIM_ARRAY_HOLD_EN
    assign hold_w = HOLD;
`else
    assign hold_w = 1'b0;
`endif

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                reg_1_d[r][c] = reg_1_q[r][c];
            end
            for (int k = 0; k < 3; k++) begin
                reg_2_d[r][k] = reg_2_q[r][k];
            end
            if (!hold_w) begin
                reg_1_d[r][0] = reg_1_q[r][0] + ONE;
                reg_1_d[r][1] = reg_1_q[r][1] + ONE;
                // Row sum wraps modulo 2^width; the carry is intentionally dropped.
                reg_2_d[r][0] = reg_1_q[r][0] + reg_1_q[r][1];
                reg_2_d[r][1] = reg_2_q[r][0];
                reg_2_d[r][2] = reg_2_q[r][1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    reg_1_q[r][c] <= BIT_WIDTH_REG_1'(2 * r + c);
                end
                for (int k = 0; k < 3; k++) begin
                    reg_2_q[r][k] <= '0;
                end
            end
        end else begin
            reg_1_q <= reg_1_d;
            reg_2_q <= reg_2_d;
        end
    end

    assign OUT_REG_1_A = reg_1_q[0][0];
    assign OUT_REG_1_B = reg_1_q[0][1];
    assign OUT_REG_1_C = reg_1_q[1][0];
    assign OUT_REG_1_D = reg_1_q[1][1];
    assign OUT_REG_2_A = reg_2_q[0][0];
    assign OUT_REG_2_B = reg_2_q[0][1];
    assign OUT_REG_2_C = reg_2_q[0][2];
    assign OUT_REG_2_D = reg_2_q[1][0];
    assign OUT_REG_2_E = reg_2_q[1][1];
    assign OUT_REG_2_F = reg_2_q[1][2];

endmodule

// File: tb/tb_multi_dim_array_regs.sv
// Self-checking bench for multi_dim_array_regs (width 8): vector table, closed-form scoreboard, wrap and reset corners.
module tb_multi_dim_array_regs;

    typedef struct packed {
        logic [3:0][7:0] r1;   // [0]=A .. [3]=D
        logic [5:0][7:0] r2;   // [0]=A .. [5]=F
    } exp_t;

    typedef struct {
        bit   rst;
        exp_t e;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] o1a, o1b, o1c, o1d, o2a, o2b, o2c, o2d, o2e, o2f;
`ifdef MULTI_DIM_ARRAY_HOLD_EN
    logic       hold;
`endif

    int   n_checks;
    int   n_fail;
    int   n_edges;
    exp_t sb_q[$];

    multi_dim_array_regs #(.BIT_WIDTH_REG_1(8)) dut (
        .CLK(clk),
        .RST(rst),
`ifdef MULTI_DIM_ARRAY_HOLD_EN
        .HOLD(hold),
`endif
        .OUT_REG_1_A(o1a), .OUT_REG_1_B(o1b), .OUT_REG_1_C(o1c), .OUT_REG_1_D(o1d),
        .OUT_REG_2_A(o2a), .OUT_REG_2_B(o2b), .OUT_REG_2_C(o2c),
        .OUT_REG_2_D(o2d), .OUT_REG_2_E(o2e), .OUT_REG_2_F(o2f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed form: after n free edges since reset, counter value is its reset value plus n,
    // and column k of row r holds the row sum taken k+1 edges earlier.
    function automatic exp_t exp_of(int n);
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) e.r1[2*r+c] = 8'(2*r + c + n);
            for (int k = 0; k < 3; k++)
                e.r2[3*r+k] = (n > k) ? 8'(4*r + 2*(n-1-k) + 1) : 8'd0;
        end
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.r1 = {o1d, o1c, o1b, o1a};
        a.r2 = {o2f, o2e, o2d, o2c, o2b, o2a};
        return a;
    endfunction

    task automatic cmp(string name, logic [7:0] act, logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge count %0d)", name, act, req, n_edges);
        end
    endtask

    task automatic check_all(string tag, exp_t e);
        exp_t a = actual();
        for (int i = 0; i < 4; i++) cmp($sformatf("%s REG_1[%0d]", tag, i), a.r1[i], e.r1[i]);
        for (int i = 0; i < 6; i++) cmp($sformatf("%s REG_2[%0d]", tag, i), a.r2[i], e.r2[i]);
    endtask

    task automatic tick(bit r, bit h);
        rst = r;
`ifdef MULTI_DIM_ARRAY_HOLD_EN
        hold = h;
`endif
        @(posedge clk);
        #1;
        if (r) n_edges = 0;
`ifdef MULTI_DIM_ARRAY_HOLD_EN
        else if (!h) n_edges++;
`else
        else n_edges++;
`endif
    endtask

    task automatic sb_step(string tag, bit r, bit h, exp_t e);
        exp_t got;
        sb_q.push_back(e);
        tick(r, h);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            check_all(tag, got);
        end
    endtask

    vec_t tbl[5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_edges  = 0;
        rst      = 1'b1;
`ifdef MULTI_DIM_ARRAY_HOLD_EN
        hold     = 1'b0;
`endif

        tbl[0].rst = 1'b1; tbl[0].e.r1 = {8'd3, 8'd2, 8'd1, 8'd0}; tbl[0].e.r2 = '0;
        tbl[1].rst = 1'b1; tbl[1].e.r1 = {8'd3, 8'd2, 8'd1, 8'd0}; tbl[1].e.r2 = '0;
        tbl[2].rst = 1'b0; tbl[2].e.r1 = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[2].e.r2 = {8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd1};
        tbl[3].rst = 1'b0; tbl[3].e.r1 = {8'd5, 8'd4, 8'd3, 8'd2};
        tbl[3].e.r2 = {8'd0, 8'd5, 8'd7, 8'd0, 8'd1, 8'd3};
        tbl[4].rst = 1'b0; tbl[4].e.r1 = {8'd6, 8'd5, 8'd4, 8'd3};
        tbl[4].e.r2 = {8'd5, 8'd7, 8'd9, 8'd1, 8'd3, 8'd5};

        for (int i = 0; i < 5; i++) sb_step($sformatf("vec%0d", i), tbl[i].rst, 1'b0, tbl[i].e);

        // Free run through counter and row-sum wrap.
        while (n_edges < 260) begin
            sb_step("run", 1'b0, 1'b0, exp_of(n_edges + 1));
            if (n_edges == 128) cmp("sum 127+128", o2a, 8'd255);
            if (n_edges == 129) cmp("sum 128+129 wrap", o2a, 8'd1);
            if (n_edges == 252) cmp("D at 252", o1d, 8'd255);
            if (n_edges == 253) begin
                cmp("D wrap at 253", o1d, 8'd0);
                cmp("C at 253", o1c, 8'd255);
            end
        end

        // Mid-run reset after 10 free edges.
        sb_step("rst", 1'b1, 1'b0, exp_of(0));
        for (int i = 0; i < 10; i++) sb_step("pre", 1'b0, 1'b0, exp_of(n_edges + 1));
        sb_step("midrst", 1'b1, 1'b0, exp_of(0));
        sb_step("post1", 1'b0, 1'b0, tbl[2].e);

`ifdef MULTI_DIM_ARRAY_HOLD_EN
        sb_step("post2", 1'b0, 1'b0, tbl[3].e);
        for (int i = 0; i < 5; i++) sb_step("hold", 1'b0, 1'b1, tbl[3].e);
        sb_step("release", 1'b0, 1'b0, tbl[4].e);
        sb_step("rst+hold", 1'b1, 1'b1, tbl[0].e);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_dim_array_regs.md
Name: multi_dim_array_regs

Overview:
- Demonstration/utility block that stores state in two 2-D register arrays and exposes every element as a flat output port.
- REG_1 is a 2x2 array of free-running counters.
- REG_2 is a 2x3 array: per row, a 3-stage delay line of that row's REG_1 sum.
- Sits at top level as a self-running pattern source; no data inputs.

Parameters:
- BIT_WIDTH_REG_1, 8, width of every element of REG_1 and REG_2 (>=2).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- OUT_REG_1_A  output  BIT_WIDTH_REG_1  REG_1[0][0]
- OUT_REG_1_B  output  BIT_WIDTH_REG_1  REG_1[0][1]
- OUT_REG_1_C  output  BIT_WIDTH_REG_1  REG_1[1][0]
- OUT_REG_1_D  output  BIT_WIDTH_REG_1  REG_1[1][1]
- OUT_REG_2_A  output  BIT_WIDTH_REG_1  REG_2[0][0]
- OUT_REG_2_B  output  BIT_WIDTH_REG_1  REG_2[0][1]
- OUT_REG_2_C  output  BIT_WIDTH_REG_1  REG_2[0][2]
- OUT_REG_2_D  output  BIT_WIDTH_REG_1  REG_2[1][0]
- OUT_REG_2_E  output  BIT_WIDTH_REG_1  REG_2[1][1]
- OUT_REG_2_F  output  BIT_WIDTH_REG_1  REG_2[1][2]

Behaviour:
- One clock (CLK); reset RST is synchronous and active-high.
- All outputs driven directly from registers; no combinational paths.
- Reset, sampled at a rising edge with RST=1:
  - REG_1[r][c] <= 2*r+c, i.e. A=0, B=1, C=2, D=3.
  - All REG_2 elements <= 0.
- Normal operation, each rising edge with RST=0; all right-hand sides use pre-edge values:
  - REG_1[r][c] <= REG_1[r][c] + 1, modulo 2^BIT_WIDTH_REG_1; wraps max->0 silently.
  - REG_2[r][0] <= (REG_1[r][0] + REG_1[r][1]) mod 2^BIT_WIDTH_REG_1; carry discarded.
  - REG_2[r][1] <= REG_2[r][0]; REG_2[r][2] <= REG_2[r][1].
- Latency: a row sum appears in column 0 one cycle after the REG_1 values it uses, column 1 two cycles after, column 2 three cycles after.
- Reset mid-operation: all arrays return to reset values at that edge, regardless of prior state. Counting resumes on the first edge with RST=0.
- Reset held for multiple cycles: values stay constant at reset values.
- Before the first reset, register contents are undefined; no power-up initialisation is required.
- Arrays are declared as true 2-D arrays internally; the output mapping is the fixed one listed under Ports.

Optional Feature:
- Macro MULTI_DIM_ARRAY_HOLD_EN.
- Defined:
  - Adds input port HOLD (1 bit) after RST.
  - When HOLD=1 and RST=0, all REG_1 and REG_2 elements keep their values at that edge.
  - RST has priority over HOLD.
- Undefined: no HOLD port; registers update every non-reset edge as described above.

Test Plan (BIT_WIDTH_REG_1=8):
- Reset: RST=1 for 2 edges -> REG_1 outputs A..D = 0,1,2,3; REG_2 outputs A..F all 0.
- After reset release:
  - Edge 1: REG_1 = 1,2,3,4; REG_2 A..F = 1,0,0,5,0,0.
  - Edge 2: REG_1 = 2,3,4,5; REG_2 = 3,1,0,7,5,0.
  - Edge 3: REG_1 = 3,4,5,6; REG_2 = 5,3,1,9,7,5.
- Wrap: run 252 edges after reset -> OUT_REG_1_D=255; edge 253 -> OUT_REG_1_D=0, OUT_REG_1_C=255. Row sums wrap mod 256, e.g. 127+128=255, then 128+129 -> 1.
- Mid-run reset: after 10 free edges assert RST for 1 edge -> all outputs back to 0,1,2,3 / zeros; next edge matches post-reset edge 1 values.
- With MULTI_DIM_ARRAY_HOLD_EN defined:
  - HOLD=1 for 5 edges after edge 2 -> outputs frozen at edge-2 values.
  - Release HOLD -> next edge yields edge-3 values.
  - RST=1 with HOLD=1 -> reset values.
